// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one nBit_Shift core; SHIFT_ARB_COUNT_EN adds the ops counter
// nBit_Shift: bit0 direction (1 = right), bits[WIDTH-2:1] amount, MSB fill.

module nBit_Shift #(
    parameter int WIDTH = 4,
    parameter int OP    = 0
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] shift_i,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] overflow_o
);
    localparam logic [WIDTH-1:0] W_L      = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] AMT_MASK = {WIDTH{1'b1}} >> 2;
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

    logic             fill, rfill;
    logic [WIDTH-1:0] amt_raw, amt;

    always_comb begin
        fill    = shift_i[WIDTH-1];
        rfill   = (OP == 1) ? in_i[WIDTH-1] : fill;
        amt_raw = (shift_i >> 1) & AMT_MASK;
        // Amounts past the word width saturate so vacated bits still take the fill value.
        amt     = (amt_raw > W_L) ? W_L : amt_raw;
        if (shift_i[0]) begin
            out_o      = (in_i >> amt) | (~(ONES >> amt) & {WIDTH{rfill}});
            overflow_o = (amt == '0) ? '0 : (in_i << (W_L - amt));
        end else begin
            out_o      = (in_i << amt) | (~(ONES << amt) & {WIDTH{fill}});
            overflow_o = (amt == '0) ? '0 : (in_i >> (W_L - amt));
        end
    end
endmodule

module shift_arbiter #(
    parameter int WIDTH = 4,
    parameter int REQS  = 4,
    parameter int OP    = 0,
    localparam int ID_W = ($clog2(REQS) > 1) ? $clog2(REQS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQS-1:0]       req_valid,
    output logic [REQS-1:0]       req_ready,
    input  logic [REQS*WIDTH-1:0] req_in,
    input  logic [REQS*WIDTH-1:0] req_shift,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_out,
    output logic [WIDTH-1:0]      rsp_overflow,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           ops_count
);
    if (WIDTH < 2) begin : g_bad_width
        $error("shift_arbiter: WIDTH must be >= 2");
    end
    if (REQS < 2) begin : g_bad_reqs
        $error("shift_arbiter: REQS must be >= 2");
    end

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] out_q, ovf_q;
    logic [ID_W-1:0]  id_q, last_q;

    logic             found, accept;
    logic [ID_W-1:0]  grant, idx;
    logic [WIDTH-1:0] op_in, op_sh, core_out, core_ovf;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = last_q;
        for (int k = 0; k < REQS; k++) begin
            idx = (idx == ID_W'(REQS - 1)) ? '0 : idx + ID_W'(1);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        accept = rst_n && found && (state_q == EMPTY || rsp_ready);
    end

    always_comb begin
        op_in     = '0;
        op_sh     = '0;
        req_ready = '0;
        for (int i = 0; i < REQS; i++) begin
            if (grant == ID_W'(i)) begin
                op_in        = req_in[i*WIDTH +: WIDTH];
                op_sh        = req_shift[i*WIDTH +: WIDTH];
                req_ready[i] = accept;
            end
        end
    end

    nBit_Shift #(.WIDTH(WIDTH), .OP(OP)) u_core (
        .in_i       (op_in),
        .shift_i    (op_sh),
        .out_o      (core_out),
        .overflow_o (core_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            ovf_q   <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(REQS - 1);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_q   <= core_out;
                        ovf_q   <= core_ovf;
                        id_q    <= grant;
                        last_q  <= grant;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (accept) begin
                        out_q   <= core_out;
                        ovf_q   <= core_ovf;
                        id_q    <= grant;
                        last_q  <= grant;
                    end else if (rsp_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign rsp_valid    = (state_q == FULL);
    assign rsp_out      = out_q;
    assign rsp_overflow = ovf_q;
    assign rsp_id       = id_q;

`ifdef SHIFT_ARB_COUNT_EN
    logic [15:0] ops_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q <= '0;
        end else if (rsp_valid && rsp_ready && ops_q != 16'hFFFF) begin
            ops_q <= ops_q + 16'd1;
        end
    end

    assign ops_count = ops_q;
`else
    assign ops_count = '0;
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter (WIDTH=4, REQS=4, OP=0)

module tb_shift_arbiter;
    typedef struct packed {
        logic [3:0] out;
        logic [3:0] ovf;
        logic [1:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_in, req_shift;
    logic        rsp_valid, rsp_ready;
    logic [3:0]  rsp_out, rsp_overflow;
    logic [1:0]  rsp_id;
    logic [15:0] ops_count;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   hs_count = 0;

    localparam exp_t R0 = '{out: 4'b0110, ovf: 4'b0000, id: 2'd0};
    localparam exp_t R1 = '{out: 4'b1100, ovf: 4'b1000, id: 2'd1};
    localparam exp_t R2 = '{out: 4'b0100, ovf: 4'b0000, id: 2'd2};
    localparam exp_t R3 = '{out: 4'b1011, ovf: 4'b0001, id: 2'd3};

    shift_arbiter #(.WIDTH(4), .REQS(4), .OP(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_in       (req_in),
        .req_shift    (req_shift),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_out      (rsp_out),
        .rsp_overflow (rsp_overflow),
        .rsp_id       (rsp_id),
        .ops_count    (ops_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] s);
        req_in[i*4 +: 4]    = a;
        req_shift[i*4 +: 4] = s;
    endtask

    task automatic cycle(input logic [3:0] valid, input logic rdy,
                         input logic [3:0] exp_ready, input exp_t e);
        @(posedge clk);
        #1;
        req_valid = valid;
        rsp_ready = rdy;
        @(negedge clk);
        check("req_ready", {12'd0, req_ready}, {12'd0, exp_ready});
        if (exp_ready != 4'b0000) sbq.push_back(e);
    endtask

    task automatic check_ops();
`ifdef SHIFT_ARB_COUNT_EN
        check("ops_count", ops_count, (hs_count > 65535) ? 16'hFFFF : 16'(hs_count));
`else
        check("ops_count", ops_count, 16'd0);
`endif
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                hs_count++;
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rsp: got id %0d out %b, expected no response", rsp_id, rsp_out);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_out", {12'd0, rsp_out}, {12'd0, e.out});
                    check("rsp_overflow", {12'd0, rsp_overflow}, {12'd0, e.ovf});
                    check("rsp_id", {14'd0, rsp_id}, {14'd0, e.id});
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_in    = '0;
        req_shift = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("reset_rsp_out", {12'd0, rsp_out}, 16'd0);
        check("reset_rsp_overflow", {12'd0, rsp_overflow}, 16'd0);
        check("reset_rsp_id", {14'd0, rsp_id}, 16'd0);
        check("reset_req_ready", {12'd0, req_ready}, 16'd0);
        check("reset_ops_count", ops_count, 16'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        set_req(0, 4'b0011, 4'b0010);
        set_req(1, 4'b1001, 4'b1011);
        set_req(2, 4'b1000, 4'b0011);
        set_req(3, 4'b0110, 4'b1100);

        // Single left shift, then drain to EMPTY with stale data held.
        cycle(4'b0001, 1'b1, 4'b0001, R0);
        cycle(4'b0000, 1'b1, 4'b0000, '0);
        check("latency_valid", {15'd0, rsp_valid}, 16'd1);
        cycle(4'b0000, 1'b1, 4'b0000, '0);
        check("drained_valid", {15'd0, rsp_valid}, 16'd0);
        check("stale_out", {12'd0, rsp_out}, 16'b0110);

        // Right shift from requester 2.
        cycle(4'b0100, 1'b1, 4'b0100, R2);
        cycle(4'b0000, 1'b1, 4'b0000, '0);
        cycle(4'b0000, 1'b1, 4'b0000, '0);

        // Fairness: after a grant to 3, all-valid rotates 0,1,2,3,0 back to back.
        cycle(4'b1000, 1'b1, 4'b1000, R3);
        cycle(4'b1111, 1'b1, 4'b0001, R0);
        cycle(4'b1111, 1'b1, 4'b0010, R1);
        cycle(4'b1111, 1'b1, 4'b0100, R2);
        cycle(4'b1111, 1'b1, 4'b1000, R3);
        cycle(4'b1111, 1'b1, 4'b0001, R0);

        // Backpressure: FULL holding requester 0's result.
        for (int c = 0; c < 3; c++) begin
            cycle(4'b0010, 1'b0, 4'b0000, '0);
            check("bp_valid", {15'd0, rsp_valid}, 16'd1);
            check("bp_out", {12'd0, rsp_out}, {12'd0, R0.out});
            check("bp_id", {14'd0, rsp_id}, {14'd0, R0.id});
        end
        cycle(4'b0010, 1'b1, 4'b0010, R1);
        cycle(4'b0000, 1'b0, 4'b0000, '0);
        check("no_bubble_valid", {15'd0, rsp_valid}, 16'd1);
        check("no_bubble_out", {12'd0, rsp_out}, {12'd0, R1.out});
        check("no_bubble_id", {14'd0, rsp_id}, {14'd0, R1.id});
        check_ops();

        // Asynchronous reset while FULL discards the held result.
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b1001;
        sbq.delete();
        hs_count  = 0;
        #1;
        check("midrst_valid", {15'd0, rsp_valid}, 16'd0);
        check("midrst_out", {12'd0, rsp_out}, 16'd0);
        check("midrst_overflow", {12'd0, rsp_overflow}, 16'd0);
        check("midrst_id", {14'd0, rsp_id}, 16'd0);
        check("midrst_req_ready", {12'd0, req_ready}, 16'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant", {12'd0, req_ready}, 16'b0001);
        sbq.push_back(R0);
        cycle(4'b1000, 1'b1, 4'b1000, R3);
        cycle(4'b0000, 1'b1, 4'b0000, '0);
        cycle(4'b0000, 1'b1, 4'b0000, '0);
        check("sb_empty", 16'(sbq.size()), 16'd0);
        check_ops();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
